// File: rtl/adc_sample_sched.sv
// Periodic ADC conversion-request scheduler with req/ack handshake, burst/continuous counting and overrun flag.
// Optional ADC_SCHED_BLINK_EN: tick_led toggles on every accepted conv_ack; otherwise tied low.
module adc_sample_sched #(
  parameter int unsigned DIV_W   = 32,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned MIN_DIV = 2
) (
  input  logic             clk_in,
  input  logic             Res,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] div_val,
  input  logic [CNT_W-1:0] burst_len,
  output logic             conv_req,
  input  logic             conv_ack,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_idx,
  output logic             overrun,
  output logic             tick_led
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_WAIT_ACK,
    ST_DONE
  } state_t;

  localparam logic [DIV_W-1:0] MIN_P = DIV_W'(MIN_DIV);

  state_t           state, state_n;
  logic [DIV_W-1:0] period, period_n;
  logic [DIV_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] burst, burst_n;
  logic [CNT_W-1:0] idx_n, idx_inc;
  logic             req_n, ovr_n, done_n;
  logic             expiry, burst_end;

  always_comb begin
    expiry    = (cnt == period - DIV_W'(1));
    idx_inc   = sample_idx + CNT_W'(1);
    burst_end = (burst != '0) && (idx_inc == burst);

    state_n  = state;
    period_n = period;
    burst_n  = burst;
    cnt_n    = cnt;
    req_n    = conv_req;
    idx_n    = sample_idx;
    ovr_n    = overrun;
    done_n   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          period_n = (div_val < MIN_P) ? MIN_P : div_val;
          burst_n  = burst_len;
          idx_n    = '0;
          ovr_n    = 1'b0;
          cnt_n    = '0;
          state_n  = ST_RUN;
        end
      end
      ST_RUN, ST_WAIT_ACK: begin
        cnt_n = expiry ? '0 : cnt + DIV_W'(1);
        if (stop) begin
          req_n   = 1'b0;
          cnt_n   = '0;
          state_n = ST_IDLE;
        end else if (state == ST_RUN) begin
          if (expiry) begin
            req_n   = 1'b1;
            state_n = ST_WAIT_ACK;
          end
        end else if (conv_ack) begin
          idx_n = idx_inc;
          if (burst_end) begin
            req_n   = 1'b0;
            done_n  = 1'b1;
            state_n = ST_DONE;
          end else if (expiry) begin
            // ack coincides with a new period: that period's request is issued at once
            req_n = 1'b1;
          end else begin
            req_n   = 1'b0;
            state_n = ST_RUN;
          end
        end else if (expiry) begin
          ovr_n = 1'b1;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (Res) begin
      state      <= ST_IDLE;
      period     <= '0;
      burst      <= '0;
      cnt        <= '0;
      conv_req   <= 1'b0;
      sample_idx <= '0;
      overrun    <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      period     <= period_n;
      burst      <= burst_n;
      cnt        <= cnt_n;
      conv_req   <= req_n;
      sample_idx <= idx_n;
      overrun    <= ovr_n;
      done       <= done_n;
      busy       <= (state_n != ST_IDLE);
    end
  end

`ifdef ADC_SCHED_BLINK_EN
  logic led;
  logic ack_take, start_take;

  always_comb begin
    ack_take   = (state == ST_WAIT_ACK) && conv_ack && !stop;
    start_take = (state == ST_IDLE) && start && !stop;
  end

  always_ff @(posedge clk_in) begin
    if (Res || start_take) begin
      led <= 1'b0;
    end else if (ack_take) begin
      led <= ~led;
    end
  end

  assign tick_led = led;
`else
  assign tick_led = 1'b0;
`endif

endmodule
